// File: rtl/key_debouncer_pkg.sv
// Shared FSM state encoding and default timing constants for the key debouncer.
// Auto-repeat is enabled by defining KEY_DEBOUNCER_REPEAT_EN.
package key_debouncer_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE         = 2'd0;
    localparam state_t ST_PRESS_WAIT   = 2'd1;
    localparam state_t ST_PRESSED      = 2'd2;
    localparam state_t ST_RELEASE_WAIT = 2'd3;

    // 50 MHz clock: 20 ms debounce, 500 ms first repeat, 100 ms repeat interval
    localparam int DEF_DEBOUNCE_CYCLES = 1000000;
    localparam int DEF_REPEAT_DELAY    = 25000000;
    localparam int DEF_REPEAT_PERIOD   = 5000000;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/key_debounce_chan.sv
// One debounce channel: 2-flop synchronizer, press/release FSM and saturating counter.
// KEY_DEBOUNCER_REPEAT_EN adds an auto-repeat timer that runs only while PRESSED.
module key_debounce_chan
    import key_debouncer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_raw,
    output logic level,
    output logic press,
    output logic rel
);

    localparam int MAX_CNT = max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
    localparam int CNT_W   = $clog2(MAX_CNT + 1);
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync;
    logic             pressed;
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             rpt_fire;

    // Raw key is active-low; synchronizer resets to the released level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync <= 2'b11;
        else        sync <= {sync[0], key_raw};
    end

    assign pressed = ~sync[1];

`ifdef KEY_DEBOUNCER_REPEAT_EN
    localparam logic [CNT_W-1:0] RPT_FIRST_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RPT_NEXT_LAST  = CNT_W'(REPEAT_PERIOD - 1);

    logic [CNT_W-1:0] rpt_cnt;
    logic             rpt_first;

    assign rpt_fire = (state == ST_PRESSED) && pressed &&
                      (rpt_cnt == (rpt_first ? RPT_FIRST_LAST : RPT_NEXT_LAST));

    // Timer restarts only on a fresh press; RELEASE_WAIT leaves it frozen
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpt_cnt   <= '0;
            rpt_first <= 1'b1;
        end else if (state == ST_IDLE || state == ST_PRESS_WAIT) begin
            rpt_cnt   <= '0;
            rpt_first <= 1'b1;
        end else if (state == ST_PRESSED && pressed) begin
            if (rpt_fire) begin
                rpt_cnt   <= '0;
                rpt_first <= 1'b0;
            end else if (!(&rpt_cnt)) begin
                rpt_cnt <= rpt_cnt + 1'b1;
            end
        end
    end
`else
    assign rpt_fire = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
            rel   <= 1'b0;
        end else begin
            press <= 1'b0;
            rel   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pressed) begin
                        state <= ST_PRESS_WAIT;
                        cnt   <= '0;
                    end
                end
                ST_PRESS_WAIT: begin
                    if (!pressed) begin
                        state <= ST_IDLE;
                    end else if (cnt == DB_LAST) begin
                        state <= ST_PRESSED;
                        level <= 1'b1;
                        press <= 1'b1;
                    end else if (!(&cnt)) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_PRESSED: begin
                    if (!pressed) begin
                        state <= ST_RELEASE_WAIT;
                        cnt   <= '0;
                    end else if (rpt_fire) begin
                        press <= 1'b1;
                    end
                end
                ST_RELEASE_WAIT: begin
                    if (pressed) begin
                        state <= ST_PRESSED;
                    end else if (cnt == DB_LAST) begin
                        state <= ST_IDLE;
                        level <= 1'b0;
                        rel   <= 1'b1;
                    end else if (!(&cnt)) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/key_debouncer.sv
// Multi-key pushbutton debouncer: NUM_KEYS independent channels.
// Define KEY_DEBOUNCER_REPEAT_EN to enable held-key auto-repeat on key_press.
module key_debouncer
    import key_debouncer_pkg::*;
#(
    parameter int NUM_KEYS        = 4,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic                CLOCK_50,
    input  logic                Resetn,
    input  logic [NUM_KEYS-1:0] KEY,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release
);

    genvar i;
    generate
        for (i = 0; i < NUM_KEYS; i++) begin : g_chan
            key_debounce_chan #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .REPEAT_DELAY   (REPEAT_DELAY),
                .REPEAT_PERIOD  (REPEAT_PERIOD)
            ) u_chan (
                .clk    (CLOCK_50),
                .rst_n  (Resetn),
                .key_raw(KEY[i]),
                .level  (key_level[i]),
                .press  (key_press[i]),
                .rel    (key_release[i])
            );
        end
    endgenerate

endmodule

// File: tb/tb_key_debouncer.sv
// Directed bench for key_debouncer (NUM_KEYS=4, DEBOUNCE_CYCLES=16, REPEAT 64/32).
// Repeat expectations follow KEY_DEBOUNCER_REPEAT_EN when it is defined.
module tb_key_debouncer;

    logic       CLOCK_50 = 1'b0;
    logic       Resetn   = 1'b0;
    logic [3:0] KEY      = 4'hF;
    logic [3:0] key_level, key_press, key_release;
    int tests = 0;
    int failed = 0;

    key_debouncer #(
        .NUM_KEYS(4), .DEBOUNCE_CYCLES(16), .REPEAT_DELAY(64), .REPEAT_PERIOD(32)
    ) dut (
        .CLOCK_50(CLOCK_50), .Resetn(Resetn), .KEY(KEY),
        .key_level(key_level), .key_press(key_press), .key_release(key_release)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // Advance one edge and settle; index 1 after a drive is edge E
    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic test_reset();
        int first = 0, npress = 0, nrel = 0;
        logic [3:0] pval = 4'h0;
        KEY = 4'h0;
        Resetn = 1'b0;
        repeat (3) tick();
        tests++;
        if ({key_level, key_press, key_release} !== 12'h000) begin
            failed++;
            $display("FAIL reset_outputs: got %h, want 000", {key_level, key_press, key_release});
        end
        Resetn = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (key_press != 4'h0) begin
                npress++;
                if (first == 0) begin first = i; pval = key_press; end
            end
        end
        tests++;
        if (first !== 19 || pval !== 4'hF || npress !== 1) begin
            failed++;
            $display("FAIL reset_held_press: idx=%0d val=%h n=%0d, want idx=19 val=f n=1", first, pval, npress);
        end
        tests++;
        if (key_level !== 4'hF) begin
            failed++;
            $display("FAIL reset_held_level: got %h, want f", key_level);
        end
        KEY = 4'hF;
        first = 0;
        for (int i = 1; i <= 25; i++) begin
            tick();
            if (key_release == 4'hF) begin nrel++; if (first == 0) first = i; end
        end
        tests++;
        if (nrel !== 1 || first !== 19 || key_level !== 4'h0) begin
            failed++;
            $display("FAIL reset_release_all: n=%0d idx=%0d lvl=%h, want n=1 idx=19 lvl=0", nrel, first, key_level);
        end
    endtask

    task automatic test_clean_press();
        int pidx = 0, np = 0, ridx = 0, nr = 0, both = 0, other = 0;
        KEY[0] = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (key_press[0]) begin np++; if (pidx == 0) pidx = i; end
            if (key_press[3:1] != 3'b0 || key_release != 4'h0) other++;
        end
        tests++;
        if (pidx !== 19 || np !== 1 || other !== 0) begin
            failed++;
            $display("FAIL clean_press: idx=%0d n=%0d stray=%0d, want idx=19 n=1 stray=0", pidx, np, other);
        end
        tests++;
        if (key_level !== 4'b0001) begin
            failed++;
            $display("FAIL clean_level_high: got %b, want 0001", key_level);
        end
        KEY[0] = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (key_release[0]) begin nr++; if (ridx == 0) ridx = i; end
            if (key_press[0] && key_release[0]) both++;
            if (key_press[0]) np++;
        end
        tests++;
        if (ridx !== 19 || nr !== 1 || both !== 0 || np !== 1) begin
            failed++;
            $display("FAIL clean_release: idx=%0d n=%0d both=%0d press=%0d, want 19 1 0 1", ridx, nr, both, np);
        end
        tests++;
        if (key_level !== 4'b0000) begin
            failed++;
            $display("FAIL clean_level_low: got %b, want 0000", key_level);
        end
    endtask

    task automatic test_bounce();
        int np = 0, pidx = 0;
        KEY[1] = 1'b0;
        for (int i = 1; i <= 10; i++) begin tick(); if (key_press[1]) np++; end
        KEY[1] = 1'b1;
        for (int i = 1; i <= 2; i++) begin tick(); if (key_press[1]) np++; end
        KEY[1] = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (key_press[1]) begin np++; if (pidx == 0) pidx = i; end
        end
        tests++;
        if (np !== 1 || pidx !== 19) begin
            failed++;
            $display("FAIL bounce_press: n=%0d idx=%0d, want n=1 idx=19", np, pidx);
        end
        KEY[1] = 1'b1;
        repeat (25) tick();
    endtask

    task automatic test_release_glitch();
        int np = 0, nr = 0, lowlvl = 0;
        KEY[2] = 1'b0;
        repeat (25) tick();
        KEY[2] = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            if (key_press[2]) np++;
            if (key_release[2]) nr++;
            if (!key_level[2]) lowlvl++;
        end
        KEY[2] = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (key_press[2]) np++;
            if (key_release[2]) nr++;
            if (!key_level[2]) lowlvl++;
        end
        tests++;
        if (np !== 0 || nr !== 0 || lowlvl !== 0) begin
            failed++;
            $display("FAIL release_glitch: press=%0d rel=%0d lvl_low=%0d, want 0 0 0", np, nr, lowlvl);
        end
        KEY[2] = 1'b1;
        repeat (25) tick();
    endtask

    task automatic test_simultaneous();
        int pidx = 0, partial = 0;
        KEY = 4'h0;
        for (int i = 1; i <= 25; i++) begin
            tick();
            if (key_press == 4'hF && pidx == 0) pidx = i;
            if (key_press != 4'h0 && key_press != 4'hF) partial++;
        end
        tests++;
        if (pidx !== 19 || partial !== 0) begin
            failed++;
            $display("FAIL simultaneous: idx=%0d partial=%0d, want idx=19 partial=0", pidx, partial);
        end
        KEY = 4'hF;
        repeat (25) tick();
    endtask

    task automatic test_mid_press_reset();
        int np = 0, pidx = 0, any = 0;
        KEY[3] = 1'b0;
        repeat (22) tick();
        #2 Resetn = 1'b0;
        #1;
        tests++;
        if ({key_level, key_press, key_release} !== 12'h000) begin
            failed++;
            $display("FAIL async_reset: got %h, want 000", {key_level, key_press, key_release});
        end
        for (int i = 1; i <= 3; i++) begin
            tick();
            if ({key_level, key_press, key_release} != 12'h000) any++;
        end
        Resetn = 1'b1;
        for (int i = 1; i <= 25; i++) begin
            tick();
            if (key_press != 4'h0) begin np++; if (pidx == 0) pidx = i; end
            if (key_release != 4'h0) any++;
        end
        tests++;
        if (np !== 1 || pidx !== 19 || any !== 0 || key_level !== 4'b1000) begin
            failed++;
            $display("FAIL reset_mid_press: n=%0d idx=%0d stray=%0d lvl=%b, want 1 19 0 1000", np, pidx, any, key_level);
        end
        KEY[3] = 1'b1;
        repeat (25) tick();
    endtask

    task automatic test_repeat();
        int np = 0, bad = 0;
        bit ok;
`ifdef KEY_DEBOUNCER_REPEAT_EN
        int exp_idx [6] = '{19, 83, 115, 147, 179, 211};
        int exp_n = 6;
`else
        int exp_idx [1] = '{19};
        int exp_n = 1;
`endif
        KEY[0] = 1'b0;
        for (int i = 1; i <= 219; i++) begin
            tick();
            if (key_press[0]) begin
                np++;
                ok = 1'b0;
                foreach (exp_idx[k]) if (exp_idx[k] == i) ok = 1'b1;
                if (!ok) bad++;
            end
        end
        tests++;
        if (np !== exp_n || bad !== 0) begin
            failed++;
            $display("FAIL repeat_pulses: n=%0d misplaced=%0d, want n=%0d misplaced=0", np, bad, exp_n);
        end
        KEY[0] = 1'b1;
        repeat (25) tick();
        tests++;
        if (key_level !== 4'h0) begin
            failed++;
            $display("FAIL repeat_release_level: got %b, want 0000", key_level);
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_release_glitch();
        test_simultaneous();
        test_mid_press_reset();
        test_repeat();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
